// File: rtl/dmem_ctrl.sv
// dmem_ctrl: data-memory controller between the coherence bus and main memory.
// Ports: bus request in (message/tag/idx/data/snoop/ptr), combinational ack,
// registered load response out, proc2mem command out with retry,
// mem2proc accept-tag / return-tag / data in.
package dmem_pkg;
    localparam int TAG_W     = 56;
    localparam int IDX_W     = 5;
    localparam int WORD_W    = 64;
    localparam int RSP_PTR_W = 3;

    typedef enum logic [1:0] {
        NONE  = 2'd0,
        GET_S = 2'd1,
        GET_M = 2'd2,
        PUT_M = 2'd3
    } message_t;

    typedef enum logic [1:0] {
        BUS_NONE  = 2'd0,
        BUS_LOAD  = 2'd1,
        BUS_STORE = 2'd2
    } bus_cmd_t;

    typedef struct packed {
        logic                 store;
        logic [TAG_W-1:0]     tag;
        logic [IDX_W-1:0]     idx;
        logic [WORD_W-1:0]    data;
        logic [RSP_PTR_W-1:0] ptr;
    } req_t;
endpackage

module dmem_ctrl
    import dmem_pkg::*;
#(
    parameter int REQ_Q_DEPTH  = 4,
    parameter int NUM_MEM_TAGS = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  message_t             bus_req_message_i,
    input  logic [TAG_W-1:0]     bus_req_tag_i,
    input  logic [IDX_W-1:0]     bus_req_idx_i,
    input  logic [WORD_W-1:0]    bus_req_data_i,
    input  logic                 bus_snoop_hit_i,
    input  logic [RSP_PTR_W-1:0] bus_rsp_ptr_i,
    output logic                 Dmem_ctrl_rsp_ack_o,
    output logic                 Dmem_ctrl_rsp_vld_o,
    output logic [RSP_PTR_W-1:0] Dmem_ctrl_rsp_ptr_o,
    output logic [WORD_W-1:0]    Dmem_ctrl_rsp_data_o,
    output logic [1:0]           proc2mem_command_o,
    output logic [63:0]          proc2mem_addr_o,
    output logic [63:0]          proc2mem_data_o,
    input  logic [3:0]           mem2proc_response_i,
    input  logic [63:0]          mem2proc_data_i,
    input  logic [3:0]           mem2proc_tag_i
);

    localparam int PW = $clog2(REQ_Q_DEPTH);

    req_t                 q_mem [REQ_Q_DEPTH];
    logic [PW:0]          rd_ptr;
    logic [PW:0]          wr_ptr;
    logic [PW:0]          count;
    logic                 full;
    logic                 empty;
    logic                 mem_bound;
    logic                 push;
    logic                 pop;
    logic                 ret;
    req_t                 head;
    req_t                 new_req;
    bus_cmd_t             cmd;

    logic [NUM_MEM_TAGS-1:0] tag_vld;
    logic [RSP_PTR_W-1:0]    tag_ptr [NUM_MEM_TAGS];

    // Extra MSB on the pointers separates full from empty.
    assign count = wr_ptr - rd_ptr;
    assign full  = (count == (PW+1)'(REQ_Q_DEPTH));
    assign empty = (count == '0);
    assign head  = q_mem[rd_ptr[PW-1:0]];

    // A snoop hit means a core supplies the data, except for a
    // writeback, which always goes to memory.
    always_comb begin
        mem_bound = 1'b0;
        unique case (bus_req_message_i)
            GET_S, GET_M: mem_bound = ~bus_snoop_hit_i;
            PUT_M:        mem_bound = 1'b1;
            default:      mem_bound = 1'b0;
        endcase
    end

    // Ack looks only at the registered count, never at this cycle's pop.
    assign push = rst & mem_bound & ~full;
    assign Dmem_ctrl_rsp_ack_o = push;

    assign pop = rst & ~empty & (mem2proc_response_i != 4'd0);
    assign ret = (mem2proc_tag_i != 4'd0) & tag_vld[mem2proc_tag_i];

    always_comb begin
        new_req       = '0;
        new_req.store = (bus_req_message_i == PUT_M);
        new_req.tag   = bus_req_tag_i;
        new_req.idx   = bus_req_idx_i;
        new_req.data  = bus_req_data_i;
        new_req.ptr   = bus_rsp_ptr_i;
    end

    always_comb begin
        cmd             = BUS_NONE;
        proc2mem_addr_o = '0;
        proc2mem_data_o = '0;
        if (!empty) begin
            cmd             = head.store ? BUS_STORE : BUS_LOAD;
            proc2mem_addr_o = {head.tag, head.idx, 3'b000};
            proc2mem_data_o = head.store ? head.data : '0;
        end
    end

    assign proc2mem_command_o = cmd;

    always_ff @(posedge clk) begin
        if (push) begin
            q_mem[wr_ptr[PW-1:0]] <= new_req;
        end
        if (pop && !head.store) begin
            tag_ptr[mem2proc_response_i] <= head.ptr;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            rd_ptr               <= '0;
            wr_ptr               <= '0;
            tag_vld              <= '0;
            Dmem_ctrl_rsp_vld_o  <= 1'b0;
            Dmem_ctrl_rsp_ptr_o  <= '0;
            Dmem_ctrl_rsp_data_o <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + (PW+1)'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + (PW+1)'(1);
            end
            Dmem_ctrl_rsp_vld_o <= ret;
            if (ret) begin
                Dmem_ctrl_rsp_ptr_o  <= tag_ptr[mem2proc_tag_i];
                Dmem_ctrl_rsp_data_o <= mem2proc_data_i;
            end
            // Clear on return first so a same-tag accept wins.
            if (ret) begin
                tag_vld[mem2proc_tag_i] <= 1'b0;
            end
            if (pop && !head.store) begin
                tag_vld[mem2proc_response_i] <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_dmem_ctrl.sv
// tb_dmem_ctrl: directed plus random stimulus for dmem_ctrl, checked
// against a queue/array reference model with a decoupled response monitor.
module tb_dmem_ctrl;
    import dmem_pkg::*;

    localparam int DEPTH = 4;

    logic        clk;
    logic        rst;
    message_t    msg;
    logic [55:0] btag;
    logic [4:0]  bidx;
    logic [63:0] bdata;
    logic        snoop;
    logic [2:0]  bptr;
    logic        ack;
    logic        rvld;
    logic [2:0]  rptr;
    logic [63:0] rdata;
    logic [1:0]  cmd;
    logic [63:0] addr;
    logic [63:0] wdata;
    logic [3:0]  resp;
    logic [63:0] mdata;
    logic [3:0]  mtag;

    dmem_ctrl #(.REQ_Q_DEPTH(DEPTH), .NUM_MEM_TAGS(16)) dut (
        .clk                  (clk),
        .rst                  (rst),
        .bus_req_message_i    (msg),
        .bus_req_tag_i        (btag),
        .bus_req_idx_i        (bidx),
        .bus_req_data_i       (bdata),
        .bus_snoop_hit_i      (snoop),
        .bus_rsp_ptr_i        (bptr),
        .Dmem_ctrl_rsp_ack_o  (ack),
        .Dmem_ctrl_rsp_vld_o  (rvld),
        .Dmem_ctrl_rsp_ptr_o  (rptr),
        .Dmem_ctrl_rsp_data_o (rdata),
        .proc2mem_command_o   (cmd),
        .proc2mem_addr_o      (addr),
        .proc2mem_data_o      (wdata),
        .mem2proc_response_i  (resp),
        .mem2proc_data_i      (mdata),
        .mem2proc_tag_i       (mtag)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        bit          st;
        logic [55:0] tag;
        logic [4:0]  idx;
        logic [63:0] data;
        logic [2:0]  ptr;
    } ent_t;

    typedef struct {
        logic [2:0]  ptr;
        logic [63:0] data;
    } rsp_t;

    ent_t        mq[$];
    rsp_t        rq[$];
    bit          tv[16];
    logic [2:0]  tp[16];

    int checks = 0;
    int errors = 0;
    bit mon_on = 0;

    logic        nx_rst;
    message_t    nx_msg;
    logic [55:0] nx_tag;
    logic [4:0]  nx_idx;
    logic [63:0] nx_data;
    logic        nx_snoop;
    logic [2:0]  nx_ptr;
    logic [3:0]  nx_resp;
    logic [63:0] nx_mdata;
    logic [3:0]  nx_mtag;

    logic [1:0]  last_cmd;
    logic [63:0] last_addr;
    logic [63:0] last_data;
    logic        last_ack;

    task automatic chk(input string n, input logic [63:0] a,
                       input logic [63:0] e);
        checks++;
        if (a !== e) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", n, a, e, $time);
        end
    endtask

    task automatic idle();
        nx_rst   = 1'b1;
        nx_msg   = NONE;
        nx_tag   = '0;
        nx_idx   = '0;
        nx_data  = '0;
        nx_snoop = 1'b0;
        nx_ptr   = '0;
        nx_resp  = '0;
        nx_mdata = '0;
        nx_mtag  = '0;
    endtask

    task automatic req(input message_t m, input logic [55:0] t,
                       input logic [4:0] i, input logic [63:0] d,
                       input logic s, input logic [2:0] p);
        nx_msg   = m;
        nx_tag   = t;
        nx_idx   = i;
        nx_data  = d;
        nx_snoop = s;
        nx_ptr   = p;
    endtask

    // One cycle: apply inputs, check comb outputs, advance the model.
    task automatic step();
        ent_t h;
        ent_t e;
        bit   mb;
        bit   eack;
        @(negedge clk);
        rst   = nx_rst;
        msg   = nx_msg;
        btag  = nx_tag;
        bidx  = nx_idx;
        bdata = nx_data;
        snoop = nx_snoop;
        bptr  = nx_ptr;
        resp  = nx_resp;
        mdata = nx_mdata;
        mtag  = nx_mtag;
        #1;
        last_cmd  = cmd;
        last_addr = addr;
        last_data = wdata;
        last_ack  = ack;
        if (!nx_rst) begin
            chk("ack_in_reset", {63'd0, ack}, 64'd0);
            mq.delete();
            rq.delete();
            foreach (tv[k]) tv[k] = 0;
        end else begin
            mb = (msg == PUT_M) ||
                 ((msg == GET_S || msg == GET_M) && !snoop);
            eack = mb && (mq.size() < DEPTH);
            chk("ack", {63'd0, ack}, {63'd0, eack});
            if (mq.size() == 0) begin
                chk("cmd_idle", {62'd0, cmd}, 64'd0);
                chk("addr_idle", addr, 64'd0);
                chk("data_idle", wdata, 64'd0);
            end else begin
                h = mq[0];
                chk("cmd", {62'd0, cmd}, h.st ? 64'd2 : 64'd1);
                chk("addr", addr, {h.tag, h.idx, 3'b000});
                if (h.st) chk("wdata", wdata, h.data);
            end
            if (mtag != 0 && tv[int'(mtag)]) begin
                rq.push_back('{ptr: tp[int'(mtag)], data: mdata});
                tv[int'(mtag)] = 0;
            end
            if (mq.size() > 0 && resp != 0) begin
                h = mq.pop_front();
                if (!h.st) begin
                    tv[int'(resp)] = 1;
                    tp[int'(resp)] = h.ptr;
                end
            end
            if (eack) begin
                e.st   = (msg == PUT_M);
                e.tag  = btag;
                e.idx  = bidx;
                e.data = bdata;
                e.ptr  = bptr;
                mq.push_back(e);
            end
        end
    endtask

    task automatic do_reset();
        idle();
        nx_rst = 1'b0;
        req(GET_S, 56'h1, 5'h1, 64'h0, 1'b0, 3'd1);
        step();
        idle();
        mon_on = 1;
        @(posedge clk);
        #1;
        chk("rst_vld", {63'd0, rvld}, 64'd0);
        chk("rst_ptr", {61'd0, rptr}, 64'd0);
        chk("rst_data", rdata, 64'd0);
        chk("rst_cmd", {62'd0, cmd}, 64'd0);
        chk("rst_addr", addr, 64'd0);
        chk("rst_wdata", wdata, 64'd0);
    endtask

    // Response monitor: every registered response must match the
    // oldest expected one, which was queued in the previous cycle.
    always @(negedge clk) begin
        rsp_t x;
        if (mon_on) begin
            if (rvld === 1'b1) begin
                if (rq.size() == 0) begin
                    chk("rsp_unexpected", 64'd1, 64'd0);
                end else begin
                    x = rq.pop_front();
                    chk("rsp_ptr", {61'd0, rptr}, {61'd0, x.ptr});
                    chk("rsp_data", rdata, x.data);
                end
            end else if (rq.size() != 0) begin
                x = rq.pop_front();
                chk("rsp_missing", {63'd0, rvld}, 64'd1);
            end
        end
    end

    initial begin
        int vt[$];
        idle();
        rst = 1'b0;
        msg = NONE;
        btag = '0; bidx = '0; bdata = '0; snoop = 1'b0; bptr = '0;
        resp = '0; mdata = '0; mtag = '0;
        foreach (tv[k]) tv[k] = 0;
        do_reset();

        // Single load to 0x1000.
        req(GET_S, 56'h10, 5'h0, 64'h0, 1'b0, 3'd2);
        step();
        chk("load_ack", {63'd0, last_ack}, 64'd1);
        idle();
        nx_resp = 4'd3;
        step();
        chk("load_cmd", {62'd0, last_cmd}, 64'd1);
        chk("load_addr", last_addr, 64'h1000);
        idle();
        step();
        step();
        nx_mtag  = 4'd3;
        nx_mdata = 64'hDEAD_BEEF;
        step();
        idle();
        step();
        step();

        // Snoop hit then writeback with hit still high.
        req(GET_M, 56'h22, 5'h3, 64'h0, 1'b1, 3'd0);
        step();
        chk("snoop_noack", {63'd0, last_ack}, 64'd0);
        req(PUT_M, 56'h22, 5'h3, 64'h1234, 1'b1, 3'd0);
        step();
        chk("putm_ack", {63'd0, last_ack}, 64'd1);
        idle();
        nx_resp = 4'd4;
        step();
        chk("store_cmd", {62'd0, last_cmd}, 64'd2);
        chk("store_data", last_data, 64'h1234);
        idle();
        nx_mtag = 4'd4;
        nx_mdata = 64'h55;
        step();
        idle();
        step();

        // Backpressure: five requests with memory rejecting.
        for (int i = 0; i < 5; i++) begin
            req(GET_S, 56'(i + 1), 5'(i), 64'h0, 1'b0, 3'(i));
            step();
        end
        chk("bp_5th_noack", {63'd0, last_ack}, 64'd0);
        nx_resp = 4'd1;
        step();
        chk("bp_pop_noack", {63'd0, last_ack}, 64'd0);
        nx_resp = 4'd0;
        step();
        chk("bp_next_ack", {63'd0, last_ack}, 64'd1);
        idle();
        for (int i = 0; i < 5; i++) begin
            nx_resp = 4'(i + 6);
            step();
        end
        idle();
        for (int i = 1; i < 11; i++) begin
            nx_mtag = 4'(i);
            nx_mdata = 64'(i * 7);
            step();
        end
        idle();
        step();

        // Tag reuse in the same cycle as its return.
        do_reset();
        req(GET_S, 56'h40, 5'h1, 64'h0, 1'b0, 3'd1);
        step();
        idle();
        nx_resp = 4'd5;
        step();
        req(GET_S, 56'h41, 5'h2, 64'h0, 1'b0, 3'd6);
        step();
        idle();
        nx_resp = 4'd5;
        nx_mtag = 4'd5;
        nx_mdata = 64'hAAAA;
        step();
        idle();
        step();
        nx_mtag = 4'd5;
        nx_mdata = 64'hBBBB;
        step();
        idle();
        step();

        // Reset with two loads outstanding.
        req(GET_S, 56'h50, 5'h0, 64'h0, 1'b0, 3'd3);
        step();
        req(GET_M, 56'h51, 5'h0, 64'h0, 1'b0, 3'd4);
        nx_resp = 4'd7;
        step();
        idle();
        nx_resp = 4'd8;
        step();
        do_reset();
        nx_mtag = 4'd7;
        step();
        nx_mtag = 4'd8;
        step();
        idle();
        step();

        // Random traffic.
        for (int n = 0; n < 600; n++) begin
            idle();
            nx_rst   = ($urandom_range(0, 99) != 0);
            nx_msg   = message_t'($urandom_range(0, 3));
            nx_snoop = ($urandom_range(0, 3) == 0);
            nx_tag   = {$urandom, $urandom};
            nx_idx   = 5'($urandom);
            nx_data  = {$urandom, $urandom};
            nx_ptr   = 3'($urandom);
            nx_resp  = ($urandom_range(0, 2) == 0) ? 4'd0
                       : 4'($urandom_range(1, 15));
            nx_mdata = {$urandom, $urandom};
            vt.delete();
            for (int k = 1; k < 16; k++) if (tv[k]) vt.push_back(k);
            if (vt.size() > 0 && $urandom_range(0, 1) == 1)
                nx_mtag = 4'(vt[$urandom_range(0, vt.size() - 1)]);
            else
                nx_mtag = 4'($urandom_range(0, 15));
            step();
        end
        idle();
        step();
        step();
        step();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
